// File: rtl/i2c_slave_mem_if.sv
// i2c_slave_mem_if: bus bundle between an I2C target and the rest of the system.
//  scl_i/sda_i : sampled bus lines (already resolved, wired-AND outside)
//  sda_oe      : 1 = target pulls SDA low, 0 = released (open-drain)
//  busy        : target is addressed
//  wr_stb/wr_addr/wr_data : one-cycle write-event strobe for monitors
interface i2c_slave_mem_if #(
  parameter int AW = 4
);
  logic          scl_i;
  logic          sda_i;
  logic          sda_oe;
  logic          busy;
  logic          wr_stb;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  modport slave  (input  scl_i, sda_i, output sda_oe, busy, wr_stb, wr_addr, wr_data);
  modport master (output scl_i, sda_i, input  sda_oe, busy, wr_stb, wr_addr, wr_data);
endinterface

// File: rtl/i2c_slave_mem.sv
// i2c_slave_mem: I2C target with a MEM_DEPTH x 8 register file.
//  Oversamples SCL/SDA on clk (2-flop sync + FILT-sample stability filter),
//  decodes START/STOP/address/pointer/data, ACKs and drives SDA open-drain.
//  Writes: START, addr+W, pointer, data... ; reads: START, addr+R, data...
//  The register pointer auto-increments (wraps) and persists across transfers.
// Ports:
//  clk    : system clock (>= 8x SCL)
//  resetn : asynchronous active-low reset
//  bus    : i2c_slave_mem_if.slave (scl_i, sda_i, sda_oe, busy, wr_stb, wr_addr, wr_data)
module i2c_slave_mem #(
  parameter logic [6:0] SLV_ADDR  = 7'h50,
  parameter int         MEM_DEPTH = 16,
  parameter int         FILT      = 3,
  localparam int        AW        = $clog2(MEM_DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  i2c_slave_mem_if.slave   bus
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_ACK, WAIT_STOP
  } state_t;

  // ---------------- input conditioning ----------------
  logic [1:0]      scl_s_q, scl_s_d, sda_s_q, sda_s_d;
  logic [FILT-1:0] scl_h_q, scl_h_d, sda_h_q, sda_h_d;
  logic            scl_f_q, scl_f_d, sda_f_q, sda_f_d;
  logic            scl_p_q, sda_p_q;

  always_comb begin
    scl_s_d = {scl_s_q[0], bus.scl_i};
    sda_s_d = {sda_s_q[0], bus.sda_i};
    scl_h_d = {scl_h_q[FILT-2:0], scl_s_q[1]};
    sda_h_d = {sda_h_q[FILT-2:0], sda_s_q[1]};
    // filtered level only moves once the last FILT samples all agree
    scl_f_d = (&scl_h_q) ? 1'b1 : ((~|scl_h_q) ? 1'b0 : scl_f_q);
    sda_f_d = (&sda_h_q) ? 1'b1 : ((~|sda_h_q) ? 1'b0 : sda_f_q);
  end

  logic start_ev, stop_ev, rise_ev, fall_ev;
  assign start_ev = scl_f_q & scl_p_q &  sda_p_q & ~sda_f_q;
  assign stop_ev  = scl_f_q & scl_p_q & ~sda_p_q &  sda_f_q;
  assign rise_ev  =  scl_f_q & ~scl_p_q;
  assign fall_ev  = ~scl_f_q &  scl_p_q;

  // ---------------- protocol state ----------------
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          done_q, done_d;     // byte (or master ACK) seen; act at next SCL fall
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    tx_q, tx_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          sda_oe_q, sda_oe_d;
  logic          busy_q, busy_d;
  logic          wr_stb_q, wr_stb_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    mem_q [MEM_DEPTH];
  logic          mem_we;

  logic [7:0] shift_nx;
  logic       last_bit, addr_hit;
  logic [7:0] rd_byte;
  assign shift_nx = {shift_q[6:0], sda_f_q};
  assign last_bit = (bit_cnt_q == 3'd7);
  assign addr_hit = (shift_nx[7:1] == SLV_ADDR);
  assign rd_byte  = mem_q[ptr_q];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scl_s_q   <= '1;
      sda_s_q   <= '1;
      scl_h_q   <= '1;
      sda_h_q   <= '1;
      scl_f_q   <= 1'b1;
      sda_f_q   <= 1'b1;
      scl_p_q   <= 1'b1;
      sda_p_q   <= 1'b1;
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      done_q    <= 1'b0;
      shift_q   <= '0;
      tx_q      <= '0;
      ptr_q     <= '0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      scl_s_q   <= scl_s_d;
      sda_s_q   <= sda_s_d;
      scl_h_q   <= scl_h_d;
      sda_h_q   <= sda_h_d;
      scl_f_q   <= scl_f_d;
      sda_f_q   <= sda_f_d;
      scl_p_q   <= scl_f_q;
      sda_p_q   <= sda_f_q;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      done_q    <= done_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ptr_q     <= ptr_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      if (mem_we) mem_q[ptr_q] <= shift_nx;
    end
  end

  // next-state
  always_comb begin
    state_d = state_q;
    if (stop_ev)       state_d = IDLE;
    else if (start_ev) state_d = ADDR;
    else begin
      case (state_q)
        ADDR:      if (rise_ev && last_bit && !addr_hit) state_d = WAIT_STOP;
                   else if (fall_ev && done_q)            state_d = ADDR_ACK;
        ADDR_ACK:  if (fall_ev) state_d = shift_q[0] ? RDATA : PTR;
        PTR:       if (fall_ev && done_q) state_d = PTR_ACK;
        PTR_ACK:   if (fall_ev) state_d = WDATA;
        WDATA:     if (fall_ev && done_q) state_d = WDATA_ACK;
        WDATA_ACK: if (fall_ev) state_d = WDATA;
        RDATA:     if (fall_ev && done_q) state_d = RD_ACK;
        RD_ACK:    if (rise_ev && sda_f_q)     state_d = WAIT_STOP;
                   else if (fall_ev && done_q) state_d = RDATA;
        default:   state_d = state_q;
      endcase
    end
  end

  // outputs / datapath
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    done_d    = done_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    mem_we    = 1'b0;
    if (stop_ev) begin
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
    end else if (start_ev) begin
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (rise_ev) begin
            shift_d   = shift_nx;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
              done_d = 1'b1;
              if (state_q == PTR) ptr_d = shift_nx[AW-1:0];
              if (state_q == WDATA) begin
                mem_we    = 1'b1;
                wr_stb_d  = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = shift_nx;
                ptr_d     = ptr_q + AW'(1);
              end
            end
          end else if (fall_ev && done_q) begin
            // only a matching address reaches here in ADDR
            done_d   = 1'b0;
            sda_oe_d = 1'b1;
            if (state_q == ADDR) busy_d = 1'b1;
          end
        end
        ADDR_ACK: if (fall_ev) begin
          bit_cnt_d = '0;
          sda_oe_d  = 1'b0;
          if (shift_q[0]) begin
            tx_d     = rd_byte;
            sda_oe_d = ~rd_byte[7];
          end
        end
        PTR_ACK, WDATA_ACK: if (fall_ev) begin
          bit_cnt_d = '0;
          sda_oe_d  = 1'b0;
        end
        RDATA: begin
          if (rise_ev) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
              done_d = 1'b1;
              ptr_d  = ptr_q + AW'(1);
            end
          end else if (fall_ev) begin
            if (done_q) begin
              done_d   = 1'b0;
              sda_oe_d = 1'b0;
            end else begin
              tx_d     = {tx_q[6:0], 1'b0};
              sda_oe_d = ~tx_q[6];
            end
          end
        end
        RD_ACK: begin
          if (rise_ev && !sda_f_q) done_d = 1'b1;
          else if (fall_ev && done_q) begin
            done_d    = 1'b0;
            bit_cnt_d = '0;
            tx_d      = rd_byte;
            sda_oe_d  = ~rd_byte[7];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sda_oe  = sda_oe_q;
  assign bus.busy    = busy_q;
  assign bus.wr_stb  = wr_stb_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

endmodule
